// File: rtl/fpu_resp_merge.sv
// Writeback merge for the pipelined and DIVSQRT vector FPUs: one small FIFO per
// source, round-robin arbitration onto a single port, and sticky fflags.
module fpu_resp_merge #(
  parameter int WIDTH     = 512,
  parameter int TAG_WIDTH = 1,
  parameter int DEPTH     = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in0_valid,
  output logic                 in0_ready,
  input  logic [WIDTH-1:0]     in0_result,
  input  logic [4:0]           in0_status,
  input  logic [TAG_WIDTH-1:0] in0_tag,
  input  logic                 in1_valid,
  output logic                 in1_ready,
  input  logic [WIDTH-1:0]     in1_result,
  input  logic [4:0]           in1_status,
  input  logic [TAG_WIDTH-1:0] in1_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [4:0]           out_status,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_src,
  output logic [4:0]           fflags,
  input  logic                 fflags_clear,
  output logic                 busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = WIDTH + 5 + TAG_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    LOCK_NONE = 2'b00,
    LOCK_IN0  = 2'b01,
    LOCK_IN1  = 2'b10
  } lock_t;

  logic [EW-1:0] mem [2][DEPTH];
  logic [AW-1:0] wptr [2];
  logic [AW-1:0] rptr [2];
  logic [CW-1:0] count [2];
  logic [EW-1:0] in_entry [2];
  logic [EW-1:0] head;
  logic [1:0]    in_valid_v;
  logic [1:0]    ready_v;
  logic [1:0]    nonempty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          grant;
  logic          fire;
  logic          rr;
  lock_t         lock;
  lock_t         lock_next;

  assign in_entry[0] = {in0_tag, in0_status, in0_result};
  assign in_entry[1] = {in1_tag, in1_status, in1_result};
  assign in_valid_v  = {in1_valid, in0_valid};

  // Ready comes from the registered count alone, so a full FIFO never accepts
  // even when it is being popped in the same cycle.
  assign ready_v[0]  = (count[0] != FULL);
  assign ready_v[1]  = (count[1] != FULL);
  assign nonempty[0] = (count[0] != {CW{1'b0}});
  assign nonempty[1] = (count[1] != {CW{1'b0}});
  assign push        = in_valid_v & ready_v;

  assign in0_ready = ready_v[0];
  assign in1_ready = ready_v[1];
  assign busy      = |nonempty;

  // Grant selection, pop decode and lock next-state
  always_comb begin
    grant     = rr;
    out_valid = 1'b0;
    fire      = 1'b0;
    pop       = 2'b00;
    lock_next = LOCK_NONE;
    case (lock)
      LOCK_IN0: grant = 1'b0;
      LOCK_IN1: grant = 1'b1;
      default: begin
        if (nonempty == 2'b01) begin
          grant = 1'b0;
        end else if (nonempty == 2'b10) begin
          grant = 1'b1;
        end else begin
          grant = rr;
        end
      end
    endcase
    out_valid  = nonempty[grant];
    fire       = out_valid & out_ready;
    pop[grant] = fire;
    // A stalled head keeps its grant so valid/data stay stable until taken.
    if (out_valid && !out_ready) begin
      lock_next = grant ? LOCK_IN1 : LOCK_IN0;
    end else begin
      lock_next = LOCK_NONE;
    end
  end

  assign head       = mem[grant][rptr[grant]];
  assign out_result = head[WIDTH-1:0];
  assign out_status = head[WIDTH+4:WIDTH];
  assign out_tag    = head[EW-1:WIDTH+5];
  assign out_src    = grant;

  // Grant lock state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock <= LOCK_NONE;
    end else begin
      lock <= lock_next;
    end
  end

  // Round-robin pointer and sticky status accumulator
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr     <= 1'b0;
      fflags <= 5'b00000;
    end else begin
      if (fire) begin
        rr <= ~grant;
      end
      fflags <= (fflags_clear ? 5'b00000 : fflags) | (fire ? out_status : 5'b00000);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        wptr[k]  <= {AW{1'b0}};
        rptr[k]  <= {AW{1'b0}};
        count[k] <= {CW{1'b0}};
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          wptr[k] <= wptr[k] + AW'(1);
        end
        if (pop[k]) begin
          rptr[k] <= rptr[k] + AW'(1);
        end
        case ({push[k], pop[k]})
          2'b10:   count[k] <= count[k] + CW'(1);
          2'b01:   count[k] <= count[k] - CW'(1);
          default: count[k] <= count[k];
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility
  always_ff @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem[k][wptr[k]] <= in_entry[k];
      end
    end
  end

endmodule

// File: tb/tb_fpu_resp_merge.sv
// Directed bench for fpu_resp_merge: expected responses queue per source and a
// negedge monitor checks every delivered response against them.
module tb_fpu_resp_merge;

  localparam int WIDTH     = 512;
  localparam int TAG_WIDTH = 1;
  localparam int DEPTH     = 2;

  typedef struct packed {
    logic [WIDTH-1:0]     result;
    logic [4:0]           status;
    logic [TAG_WIDTH-1:0] tag;
  } resp_t;

  logic                 clock;
  logic                 reset;
  logic                 in0_valid, in0_ready;
  logic [WIDTH-1:0]     in0_result;
  logic [4:0]           in0_status;
  logic [TAG_WIDTH-1:0] in0_tag;
  logic                 in1_valid, in1_ready;
  logic [WIDTH-1:0]     in1_result;
  logic [4:0]           in1_status;
  logic [TAG_WIDTH-1:0] in1_tag;
  logic                 out_valid, out_ready;
  logic [WIDTH-1:0]     out_result;
  logic [4:0]           out_status;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_src;
  logic [4:0]           fflags;
  logic                 fflags_clear;
  logic                 busy;

  resp_t q0[$];
  resp_t q1[$];
  resp_t mon_exp;
  resp_t mon_got;
  int    checks = 0;
  int    errors = 0;

  fpu_resp_merge #(.WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_result(in0_result),
    .in0_status(in0_status), .in0_tag(in0_tag),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_result(in1_result),
    .in1_status(in1_status), .in1_tag(in1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_status(out_status), .out_tag(out_tag), .out_src(out_src),
    .fflags(fflags), .fflags_clear(fflags_clear), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [WIDTH-1:0] pat(input logic [31:0] k);
    return {16{k ^ 32'hC0DE_0000}};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set0(input logic [31:0] k, input logic [4:0] st, input logic [TAG_WIDTH-1:0] tg);
    in0_valid = 1'b1; in0_result = pat(k); in0_status = st; in0_tag = tg;
  endtask

  task automatic set1(input logic [31:0] k, input logic [4:0] st, input logic [TAG_WIDTH-1:0] tg);
    in1_valid = 1'b1; in1_result = pat(k); in1_status = st; in1_tag = tg;
  endtask

  task automatic expect_resp(input int src, input logic [31:0] k, input logic [4:0] st,
                             input logic [TAG_WIDTH-1:0] tg);
    resp_t e;
    e.result = pat(k); e.status = st; e.tag = tg;
    if (src == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Scoreboard monitor: every fire is matched against its source's queue head
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      mon_got = {out_result, out_status, out_tag};
      checks++;
      if ((out_src == 1'b0 && q0.size() == 0) || (out_src == 1'b1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL scoreboard: unexpected response from src%0d tag=%0h status=%b",
                 out_src, out_tag, out_status);
      end else begin
        mon_exp = (out_src == 1'b0) ? q0.pop_front() : q1.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL scoreboard src%0d: got tag=%0h status=%b result=%0h expected tag=%0h status=%b result=%0h",
                   out_src, mon_got.tag, mon_got.status, mon_got.result,
                   mon_exp.tag, mon_exp.status, mon_exp.result);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    in0_valid = 1'b0; in0_result = '0; in0_status = 5'b00000; in0_tag = '0;
    in1_valid = 1'b0; in1_result = '0; in1_status = 5'b00000; in1_tag = '0;
    out_ready = 1'b1; fflags_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_in0_ready", in0_ready, 32'd1);
    chk("rst_in1_ready", in1_ready, 32'd1);
    chk("rst_fflags", fflags, 32'd0);
    reset = 1'b0;
    tick();

    // single in0 response, visible only the cycle after the push
    set0(32'd1, 5'b00001, 1'b1); expect_resp(0, 32'd1, 5'b00001, 1'b1);
    #1 chk("t1_no_comb_path", out_valid, 32'd0);
    tick();
    in0_valid = 1'b0;
    chk("t1_out_valid", out_valid, 32'd1);
    chk("t1_out_src", out_src, 32'd0);
    chk("t1_out_tag", out_tag, 32'd1);
    chk("t1_out_result", out_result == pat(32'd1), 32'd1);
    tick();
    chk("t1_fflags", fflags, 32'd1);
    chk("t1_busy", busy, 32'd0);
    chk("t1_out_valid_after", out_valid, 32'd0);

    // both FIFOs full, round-robin alternation from in0
    reset = 1'b1; #2 reset = 1'b0;
    tick();
    chk("t2_fflags_reset", fflags, 32'd0);
    out_ready = 1'b0;
    set0(32'd10, 5'b00010, 1'b0); expect_resp(0, 32'd10, 5'b00010, 1'b0);
    set1(32'd20, 5'b00000, 1'b1); expect_resp(1, 32'd20, 5'b00000, 1'b1);
    tick();
    set0(32'd11, 5'b00000, 1'b1); expect_resp(0, 32'd11, 5'b00000, 1'b1);
    set1(32'd21, 5'b00010, 1'b0); expect_resp(1, 32'd21, 5'b00010, 1'b0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("t2_in0_full", in0_ready, 32'd0);
    chk("t2_in1_full", in1_ready, 32'd0);
    chk("t2_first_src", out_src, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_src_seq%0d", i), out_src, 32'(i % 2));
      chk($sformatf("t2_busy%0d", i), busy, 32'd1);
      tick();
    end
    chk("t2_busy_done", busy, 32'd0);
    chk("t2_fflags", fflags, 32'd2);

    // stalled in1 head holds grant despite a new in0 push
    out_ready = 1'b0;
    set1(32'd30, 5'b00100, 1'b1); expect_resp(1, 32'd30, 5'b00100, 1'b1);
    tick();
    in1_valid = 1'b0;
    chk("t3_src_first", out_src, 32'd1);
    set0(32'd31, 5'b01000, 1'b0); expect_resp(0, 32'd31, 5'b01000, 1'b0);
    tick();
    in0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_hold_valid%0d", i), out_valid, 32'd1);
      chk($sformatf("t3_hold_src%0d", i), out_src, 32'd1);
      chk($sformatf("t3_hold_status%0d", i), out_status, 32'h04);
      chk($sformatf("t3_hold_data%0d", i), (out_result == pat(32'd30)) && (out_tag == 1'b1), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_second_src", out_src, 32'd0);
    chk("t3_second_valid", out_valid, 32'd1);
    tick();
    chk("t3_fflags", fflags, 32'h0E);
    chk("t3_busy", busy, 32'd0);

    // in0 backpressure: third entry accepted only after the first fire
    out_ready = 1'b0;
    set0(32'd40, 5'b00000, 1'b0); expect_resp(0, 32'd40, 5'b00000, 1'b0);
    #1 chk("t4_ready_empty", in0_ready, 32'd1);
    tick();
    set0(32'd41, 5'b00000, 1'b1); expect_resp(0, 32'd41, 5'b00000, 1'b1);
    tick();
    set0(32'd42, 5'b00001, 1'b0);
    chk("t4_full", in0_ready, 32'd0);
    tick();
    chk("t4_still_full", in0_ready, 32'd0);
    out_ready = 1'b1;
    #1 chk("t4_no_bypass", in0_ready, 32'd0);
    tick();
    chk("t4_ready_after_fire", in0_ready, 32'd1);
    expect_resp(0, 32'd42, 5'b00001, 1'b0);
    tick();
    in0_valid = 1'b0;
    chk("t4_push_pop_ready", in0_ready, 32'd1);
    chk("t4_push_pop_valid", out_valid, 32'd1);
    tick();
    chk("t4_busy", busy, 32'd0);
    chk("t4_fflags", fflags, 32'h0F);

    // fflags clear coincident with a fire keeps that fire's status
    fflags_clear = 1'b1;
    tick();
    fflags_clear = 1'b0;
    chk("t5_cleared", fflags, 32'd0);
    set0(32'd50, 5'b00011, 1'b1); expect_resp(0, 32'd50, 5'b00011, 1'b1);
    tick();
    in0_valid = 1'b0;
    tick();
    chk("t5_pre", fflags, 32'h03);
    out_ready = 1'b0;
    set1(32'd51, 5'b10000, 1'b1); expect_resp(1, 32'd51, 5'b10000, 1'b1);
    tick();
    in1_valid = 1'b0;
    chk("t5_valid", out_valid, 32'd1);
    fflags_clear = 1'b1; out_ready = 1'b1;
    tick();
    fflags_clear = 1'b0;
    chk("t5_clear_with_fire", fflags, 32'h10);
    chk("t5_busy", busy, 32'd0);

    // async reset with entries in flight, rr pointing at in1
    out_ready = 1'b0;
    set0(32'd60, 5'b00100, 1'b0); expect_resp(0, 32'd60, 5'b00100, 1'b0);
    set1(32'd70, 5'b00001, 1'b1);
    tick();
    set0(32'd61, 5'b00001, 1'b1);
    set1(32'd71, 5'b00001, 1'b0);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t6_rr_in1", out_src, 32'd1);
    chk("t6_fflags_pre", fflags, 32'h14);
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 32'd0);
    chk("t6_busy", busy, 32'd0);
    chk("t6_fflags", fflags, 32'd0);
    chk("t6_in0_ready", in0_ready, 32'd1);
    chk("t6_in1_ready", in1_ready, 32'd1);
    q0.delete(); q1.delete();
    @(negedge clock);
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    set0(32'd80, 5'b00000, 1'b0); expect_resp(0, 32'd80, 5'b00000, 1'b0);
    set1(32'd90, 5'b00000, 1'b1); expect_resp(1, 32'd90, 5'b00000, 1'b1);
    tick();
    in0_valid = 1'b0; in1_valid = 1'b0;
    chk("t6_post_src0", out_src, 32'd0);
    tick();
    chk("t6_post_src1", out_src, 32'd1);
    tick();
    chk("t6_post_busy", busy, 32'd0);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
